// File: rtl/ps2_scan_decoder_pkg.sv
// PS/2 scan decoder shared types.
// Prefix codes, event packing and byte classifiers.
package ps2_scan_decoder_pkg;

  localparam logic [7:0] PS2_E0 = 8'hE0;
  localparam logic [7:0] PS2_F0 = 8'hF0;
  localparam int EVT_W = 11;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } pfx_e;

  typedef struct packed {
    logic       sys;
    logic       brk;
    logic       ext;
    logic [7:0] code;
  } evt_t;

  function automatic logic is_sys(input logic [7:0] b);
    case (b)
      8'hAA, 8'hFA, 8'hEE, 8'hFC,
      8'hFE, 8'h00, 8'hFF: is_sys = 1'b1;
      default:             is_sys = 1'b0;
    endcase
  endfunction

  // start low, stop high, odd parity over data+parity
  function automatic logic frame_ok(input logic [10:0] f);
    frame_ok = !f[0] && f[10] && (^f[9:1]);
  endfunction

endpackage

// File: rtl/ps2_scan_decoder_if.sv
// Key-event handshake toward the keyboard-logic stage.
// master = decoder, slave = consumer.
interface ps2_scan_decoder_if;
  logic [7:0] evt_code;
  logic       evt_ext;
  logic       evt_break;
  logic       evt_sys;
  logic       evt_valid;
  logic       evt_ready;

  modport master (
    output evt_code, evt_ext, evt_break,
    output evt_sys, evt_valid,
    input  evt_ready
  );

  modport slave (
    input  evt_code, evt_ext, evt_break,
    input  evt_sys, evt_valid,
    output evt_ready
  );
endinterface

// File: rtl/ps2_scan_decoder_evt_fifo.sv
// Synchronous show-ahead event FIFO.
// Push while full is accepted only when a pop frees the slot.
module ps2_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int EVT_W = 11
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic [EVT_W-1:0]       din,
  input  logic                   pop,
  output logic [EVT_W-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);

  logic [EVT_W-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop)
        rd_ptr <= rd_ptr + AW'(1);
      count <= count + (AW+1)'(do_push)
                     - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/ps2_scan_decoder.sv
// PS/2 frame checker and E0/F0 prefix folder.
// Queues key events and throttles the receiver when full.
module ps2_scan_decoder
  import ps2_scan_decoder_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int TIMEOUT_CYC = 100000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [10:0]            frame,
  input  logic                   frame_tick,
  output logic                   rx_en,
  ps2_scan_decoder_if.master     evt,
  output logic                   frame_err,
  output logic                   seq_err,
  output logic                   overflow
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYC - 1);

  pfx_e          state;
  pfx_e          state_nxt;
  logic [TW-1:0] tcnt;
  logic          good;
  logic [7:0]    b;
  logic          e0;
  logic          f0;
  logic          push;
  logic          pop;
  logic          serr_nxt;
  evt_t          ev;
  evt_t          head;
  logic          full;
  logic          empty;
  logic [CW-1:0] count;
  logic [CW-1:0] cnt_nxt;

  assign good = frame_ok(frame);
  assign b    = frame[8:1];
  assign e0   = b == PS2_E0;
  assign f0   = b == PS2_F0;
  assign pop  = evt.evt_valid && evt.evt_ready;

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    serr_nxt  = 1'b0;
    ev        = '0;
    ev.code   = b;
    if (frame_tick && !good) begin
      state_nxt = S_IDLE;
    end else if (frame_tick) begin
      unique case (state)
        S_IDLE:
          unique case (1'b1)
            e0:      state_nxt = S_EXT;
            f0:      state_nxt = S_BRK;
            default: begin
              push   = 1'b1;
              ev.sys = is_sys(b);
            end
          endcase
        S_EXT:
          unique case (1'b1)
            f0:      state_nxt = S_EXT_BRK;
            e0:      serr_nxt  = 1'b1;
            default: begin
              push      = 1'b1;
              ev.ext    = 1'b1;
              state_nxt = S_IDLE;
            end
          endcase
        S_BRK, S_EXT_BRK: begin
          state_nxt = S_IDLE;
          unique case (1'b1)
            (e0 || f0): serr_nxt = 1'b1;
            default: begin
              push   = 1'b1;
              ev.brk = 1'b1;
              ev.ext = state == S_EXT_BRK;
            end
          endcase
        end
      endcase
    end else if (state != S_IDLE && tcnt == TLAST) begin
      // stale prefix: forget it without flagging
      state_nxt = S_IDLE;
    end
  end

  assign cnt_nxt = count
                 + CW'(push && (!full || pop))
                 - CW'(pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      tcnt      <= '0;
      frame_err <= 1'b0;
      seq_err   <= 1'b0;
      overflow  <= 1'b0;
      rx_en     <= 1'b1;
    end else begin
      state     <= state_nxt;
      if (state_nxt == S_IDLE || (frame_tick && good))
        tcnt <= '0;
      else
        tcnt <= tcnt + TW'(1);
      frame_err <= frame_tick && !good;
      seq_err   <= serr_nxt;
      overflow  <= overflow || (push && full && !pop);
      rx_en     <= cnt_nxt != CW'(DEPTH);
    end
  end

  ps2_evt_fifo #(
    .DEPTH (DEPTH),
    .EVT_W (EVT_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   (ev),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  assign evt.evt_code  = head.code;
  assign evt.evt_ext   = head.ext;
  assign evt.evt_break = head.brk;
  assign evt.evt_sys   = head.sys;
  assign evt.evt_valid = !empty;

endmodule

// File: tb/tb_ps2_scan_decoder.sv
// Bench for ps2_scan_decoder: queue-based event model,
// per-cycle compare, directed scenarios and random traffic.
module tb_ps2_scan_decoder;
  localparam int DEPTH = 8;
  localparam int TO    = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic [10:0] frame = '0;
  logic        tick = 1'b0;
  logic        rx_en;
  logic        frame_err;
  logic        seq_err;
  logic        overflow;

  ps2_scan_decoder_if ev_if ();

  ps2_scan_decoder #(
    .DEPTH       (DEPTH),
    .TIMEOUT_CYC (TO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame      (frame),
    .frame_tick (tick),
    .rx_en      (rx_en),
    .evt        (ev_if),
    .frame_err  (frame_err),
    .seq_err    (seq_err),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  // model: queue of {sys, brk, ext, code}
  logic [10:0] q [$];
  bit m_ext, m_brk;
  int cyc = 0;
  int last = 0;
  bit e_ferr, e_serr, e_ovf;

  task automatic chk(string nm, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, a, e, $time);
    end
  endtask

  function automatic bit good_f(logic [10:0] f);
    int ones = 0;
    for (int i = 1; i <= 9; i++) ones += int'(f[i]);
    return f[0] == 1'b0 && f[10] == 1'b1 && (ones % 2) == 1;
  endfunction

  function automatic logic [10:0] mk(logic [7:0] b, int err);
    logic [10:0] f;
    f = {1'b1, ~(^b), b, 1'b0};
    if (err == 1) f[9] = ~f[9];
    if (err == 2) f[0] = 1'b1;
    if (err == 3) f[10] = 1'b0;
    return f;
  endfunction

  function automatic bit sysb(logic [7:0] b);
    return b inside {8'hAA, 8'hFA, 8'hEE, 8'hFC, 8'hFE, 8'h00, 8'hFF};
  endfunction

  task automatic m_reset();
    q.delete();
    m_ext = 0; m_brk = 0;
    e_ferr = 0; e_serr = 0; e_ovf = 0;
  endtask

  task automatic m_step();
    bit pop, push;
    logic [10:0] nev;
    logic [7:0] b;
    pop = q.size() > 0 && ev_if.evt_ready === 1'b1;
    push = 0; nev = '0;
    e_ferr = 0; e_serr = 0;
    cyc++;
    if (tick) begin
      if (!good_f(frame)) begin
        e_ferr = 1; m_ext = 0; m_brk = 0;
      end else begin
        b = frame[8:1];
        if ((m_ext || m_brk) && cyc - last > TO) begin
          m_ext = 0; m_brk = 0;
        end
        last = cyc;
        if (m_brk) begin
          if (b == 8'hE0 || b == 8'hF0) e_serr = 1;
          else begin push = 1; nev = {1'b0, 1'b1, m_ext, b}; end
          m_ext = 0; m_brk = 0;
        end else if (m_ext) begin
          if (b == 8'hF0) m_brk = 1;
          else if (b == 8'hE0) e_serr = 1;
          else begin push = 1; nev = {2'b00, 1'b1, b}; m_ext = 0; end
        end else if (b == 8'hE0) m_ext = 1;
        else if (b == 8'hF0) m_brk = 1;
        else begin push = 1; nev = {sysb(b), 2'b00, b}; end
      end
    end
    if (pop) void'(q.pop_front());
    if (push) begin
      if (q.size() < DEPTH) q.push_back(nev);
      else e_ovf = 1;
    end
  endtask

  task automatic compare();
    logic [10:0] h;
    chk("valid", ev_if.evt_valid, q.size() != 0);
    if (q.size() != 0) begin
      h = q[0];
      chk("code", ev_if.evt_code, h[7:0]);
      chk("ext", ev_if.evt_ext, h[8]);
      chk("brk", ev_if.evt_break, h[9]);
      chk("sys", ev_if.evt_sys, h[10]);
    end else if (!rst_n) begin
      chk("rst_code", ev_if.evt_code, 0);
      chk("rst_flags", {ev_if.evt_ext, ev_if.evt_break, ev_if.evt_sys}, 0);
    end
    chk("rx_en", rx_en, q.size() != DEPTH);
    chk("frame_err", frame_err, e_ferr);
    chk("seq_err", seq_err, e_serr);
    chk("overflow", overflow, e_ovf);
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_reset();
        compare();
      end else begin
        compare();
        m_step();
      end
    end
  end

  task automatic cyc1();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    repeat (n) cyc1();
  endtask

  task automatic send(logic [7:0] b, int err);
    frame = mk(b, err);
    tick = 1'b1;
    cyc1();
    tick = 1'b0;
  endtask

  logic [7:0] pool [10];

  initial begin
    ev_if.evt_ready = 1'b0;
    pool = '{8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'h1C,
             8'h75, 8'hAA, 8'hFA, 8'h00, 8'h5A};
    #2 rst_n = 1'b0;
    idle(3);
    rst_n = 1'b1;
    idle(2);

    chk("pin_frame", mk(8'h1C, 0), 11'h438);
    chk("pin_badpar", good_f(mk(8'h1C, 1)), 0);

    ev_if.evt_ready = 1'b1;
    send(8'h1C, 0);
    chk("t1_valid", ev_if.evt_valid, 1);
    chk("t1_code", ev_if.evt_code, 8'h1C);
    chk("t1_flags", {ev_if.evt_sys, ev_if.evt_break, ev_if.evt_ext}, 0);
    idle(3);
    chk("t1_drain", ev_if.evt_valid, 0);

    ev_if.evt_ready = 1'b0;
    send(8'hF0, 0); send(8'h1C, 0);
    send(8'hE0, 0); send(8'hF0, 0); send(8'h75, 0);
    send(8'hE0, 0); send(8'h75, 0);
    idle(1);
    chk("t2_qsize", q.size(), 3);
    chk("t2_head", {ev_if.evt_break, ev_if.evt_ext, ev_if.evt_code}, {2'b10, 8'h1C});
    ev_if.evt_ready = 1'b1;
    cyc1();
    chk("t2_second", {ev_if.evt_break, ev_if.evt_ext, ev_if.evt_code}, {2'b11, 8'h75});
    cyc1();
    chk("t2_third", {ev_if.evt_break, ev_if.evt_ext, ev_if.evt_code}, {2'b01, 8'h75});
    idle(2);

    for (int k = 1; k <= 3; k++) begin
      send(8'h1C, k);
      chk("t3_ferr", frame_err, 1);
    end
    idle(2);
    chk("t3_noevt", ev_if.evt_valid, 0);

    ev_if.evt_ready = 1'b0;
    send(8'hE0, 0); idle(TO); send(8'h1C, 0);
    chk("t4_expired", {ev_if.evt_ext, ev_if.evt_code}, {1'b0, 8'h1C});
    send(8'hE0, 0); idle(TO - 1); send(8'h1C, 0);
    chk("t4_qsize", q.size(), 2);
    ev_if.evt_ready = 1'b1;
    idle(4);
    send(8'hF0, 0); send(8'hE0, 0);
    chk("t4_seq", seq_err, 1);
    idle(2);
    chk("t4_noevt", ev_if.evt_valid, 0);

    ev_if.evt_ready = 1'b0;
    for (int i = 0; i < DEPTH; i++) send(8'h10 + 8'(i), 0);
    chk("t5_rx_off", rx_en, 0);
    send(8'h30, 0);
    chk("t5_ovf", overflow, 1);
    chk("t5_head", ev_if.evt_code, 8'h10);
    ev_if.evt_ready = 1'b1;
    send(8'h31, 0);
    ev_if.evt_ready = 1'b0;
    chk("t5_head2", ev_if.evt_code, 8'h11);
    chk("t5_full", rx_en, 0);
    ev_if.evt_ready = 1'b1;
    idle(DEPTH + 2);

    ev_if.evt_ready = 1'b0;
    send(8'h1C, 0); send(8'h32, 0); send(8'h33, 0);
    send(8'hE0, 0); send(8'hF0, 0);
    rst_n = 1'b0;
    #1;
    chk("t6_valid", ev_if.evt_valid, 0);
    chk("t6_rx_en", rx_en, 1);
    cyc1();
    rst_n = 1'b1;
    cyc1();
    send(8'h1C, 0);
    chk("t6_evt", {ev_if.evt_valid, ev_if.evt_break, ev_if.evt_ext, ev_if.evt_code},
        {3'b100, 8'h1C});

    for (int it = 0; it < 3000; it++) begin
      int r;
      ev_if.evt_ready = $urandom_range(0, 3) != 0;
      r = $urandom_range(0, 19);
      if (r < 9) begin
        logic [7:0] b;
        b = pool[$urandom_range(0, 9)];
        if ($urandom_range(0, 7) == 0) b = 8'($urandom);
        send(b, ($urandom_range(0, 19) == 0) ? $urandom_range(1, 3) : 0);
      end else if (r == 19 && $urandom_range(0, 3) == 0) begin
        idle(TO - 2 + $urandom_range(0, 3));
      end else begin
        cyc1();
      end
    end
    ev_if.evt_ready = 1'b1;
    idle(DEPTH + 4);

    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end

endmodule
